// File: rtl/arrcmp_pkg.sv
// Shared types and constants for the array compare controller.
// The optional mismatch counter is enabled with the ARRCMP_MISMATCH_COUNT_EN macro.
package arrcmp_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 2;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } arrcmp_state_e;
endpackage

// File: rtl/array_compare_ctrl_if.sv
// Loader/checker-facing bus of the array compare controller.
// mismatch_cnt exists only when ARRCMP_MISMATCH_COUNT_EN is defined.
interface array_compare_ctrl_if
  import arrcmp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IW = $clog2(DEPTH);

  // start is a request taken only in IDLE (busy=0, done=0); done is a one-cycle
  // response that qualifies the result fields, which then hold until the next accepted start.
  logic             wr_en;
  logic             wr_sel;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             match;
  logic             mismatch_valid;
  logic [IW-1:0]    mismatch_idx;
  logic             wr_err;
`ifdef ARRCMP_MISMATCH_COUNT_EN
  logic [IW:0]      mismatch_cnt;
`endif
  arrcmp_state_e    state;

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, start,
    input  busy, done, match, mismatch_valid, mismatch_idx, wr_err, state
`ifdef ARRCMP_MISMATCH_COUNT_EN
    , input mismatch_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, start,
    output busy, done, match, mismatch_valid, mismatch_idx, wr_err, state
`ifdef ARRCMP_MISMATCH_COUNT_EN
    , output mismatch_cnt
`endif
  );
endinterface

// File: rtl/arrcmp_bank.sv
// Dual register bank (A and B): one write port, two combinational reads at a shared index.
module arrcmp_bank
  import arrcmp_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter int  WIDTH = DEF_WIDTH,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b
);
  logic [WIDTH-1:0] bank_a [DEPTH];
  logic [WIDTH-1:0] bank_b [DEPTH];

  // wr_en arrives pre-qualified, so wr_idx is always in range here.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_sel == BANK_B) bank_b[wr_idx] <= wr_data;
      else                  bank_a[wr_idx] <= wr_data;
    end
  end

  assign rd_a = bank_a[rd_idx];
  assign rd_b = bank_b[rd_idx];
endmodule

// File: rtl/array_compare_ctrl.sv
// Walks banks A and B one element per cycle and reports match / first mismatch / done.
// Define ARRCMP_MISMATCH_COUNT_EN to add the differing-element counter.
module array_compare_ctrl
  import arrcmp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  array_compare_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  arrcmp_state_e    state_q;
  logic [IW-1:0]    scan_idx;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             busy_q, done_q, match_q, mv_q, wr_err_q;
  logic [IW-1:0]    midx_q;
  logic             wr_ok, diff, last;
`ifdef ARRCMP_MISMATCH_COUNT_EN
  logic [IW:0]      cnt_q;
`endif

  assign wr_ok = bus.wr_en && (state_q == IDLE) && ({1'b0, bus.wr_idx} < DEPTH_W);
  assign diff  = (rd_a != rd_b);
  assign last  = (scan_idx == IW'(DEPTH - 1));

  arrcmp_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .clr     (!rst_n),
    .wr_en   (wr_ok),
    .wr_sel  (bus.wr_sel),
    .wr_idx  (bus.wr_idx),
    .wr_data (bus.wr_data),
    .rd_idx  (scan_idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      scan_idx <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      mv_q     <= 1'b0;
      midx_q   <= '0;
      wr_err_q <= 1'b0;
`ifdef ARRCMP_MISMATCH_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= bus.wr_en && !wr_ok;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q  <= CMP;
            scan_idx <= '0;
            busy_q   <= 1'b1;
            match_q  <= 1'b0;
            mv_q     <= 1'b0;
            midx_q   <= '0;
`ifdef ARRCMP_MISMATCH_COUNT_EN
            cnt_q    <= '0;
`endif
          end
        end
        CMP: begin
          if (diff && !mv_q) begin
            mv_q   <= 1'b1;
            midx_q <= scan_idx;
          end
`ifdef ARRCMP_MISMATCH_COUNT_EN
          cnt_q <= cnt_q + (IW+1)'(diff);
`endif
          // The last element's verdict is folded into match in the same edge.
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= !(mv_q || diff);
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.match          = match_q;
  assign bus.mismatch_valid = mv_q;
  assign bus.mismatch_idx   = midx_q;
  assign bus.wr_err         = wr_err_q;
  assign bus.state          = state_q;
`ifdef ARRCMP_MISMATCH_COUNT_EN
  assign bus.mismatch_cnt   = cnt_q;
`endif
endmodule

// File: tb/tb_array_compare_ctrl.sv
// Scoreboard bench for array_compare_ctrl: directed vectors, expected results queued at start.
module tb_array_compare_ctrl;
  import arrcmp_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = 23;  // {done_cycle[15:0], match, mismatch_valid, idx[1:0], cnt[2:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cyc = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   err_q[$];
  logic [EW-1:0] e;
  logic [15:0]   ec;

  array_compare_ctrl_if #(.DEPTH(4), .WIDTH(2)) bus ();
  array_compare_ctrl_if #(.DEPTH(5), .WIDTH(2)) bus5 ();

  array_compare_ctrl #(.DEPTH(4), .WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  array_compare_ctrl #(.DEPTH(5), .WIDTH(2)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [15:0] c, input logic m, input logic mv,
                                         input logic [1:0] idx, input logic [2:0] cnt);
`ifdef ARRCMP_MISMATCH_COUNT_EN
    return {c, m, mv, idx, cnt};
`else
    if (cnt != 3'd0) return {c, m, mv, idx, 3'd0};
    return {c, m, mv, idx, cnt};
`endif
  endfunction

  function automatic logic [2:0] dut_cnt();
`ifdef ARRCMP_MISMATCH_COUNT_EN
    return bus.mismatch_cnt;
`else
    return 3'd0;
`endif
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({cyc, bus.match, bus.mismatch_valid, bus.mismatch_idx, dut_cnt()}), 32'(e));
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
    if (rst_n && bus.wr_err) begin
      if (err_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_wr_err: got wr_err at cycle %0d, expected none", cyc);
      end else begin
        ec = err_q.pop_front();
        check("wr_err_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // driver tasks: entered and left at a negedge
  task automatic write_el(input logic sel, input logic [1:0] idx, input logic [1:0] data, input logic bad);
    if (bad) err_q.push_back(cyc + 16'd1);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_idx = idx; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic start_cmp(input logic track, input logic m, input logic mv,
                           input logic [1:0] idx, input logic [2:0] cnt);
    if (track) exp_q.push_back(pack(cyc + 16'd1 + 16'(DEPTH), m, mv, idx, cnt));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic write_start(input logic sel, input logic [1:0] idx, input logic [1:0] data,
                             input logic m, input logic mv, input logic [1:0] eidx, input logic [2:0] cnt);
    exp_q.push_back(pack(cyc + 16'd1 + 16'(DEPTH), m, mv, eidx, cnt));
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_idx = idx; bus.wr_data = data;
    bus.start = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  logic [1:0] va [4];
  logic [1:0] vb [4];

  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.start = 1'b0;
    bus5.wr_en = 1'b0; bus5.wr_sel = 1'b0; bus5.wr_idx = '0; bus5.wr_data = '0; bus5.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.busy, bus.done, bus.match, bus.mismatch_valid,
                                bus.mismatch_idx, bus.wr_err}), 32'd0);
    rst_n = 1'b1;

    // equal arrays
    va = '{2'd1, 2'd2, 2'd3, 2'd0};
    vb = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      write_el(BANK_A, 2'(i), va[i], 1'b0);
      write_el(BANK_B, 2'(i), vb[i], 1'b0);
    end
    start_cmp(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
    drain();

    // B={1,3,3,1}: first mismatch at 1, two differing
    write_el(BANK_B, 2'd1, 2'd3, 1'b0);
    write_el(BANK_B, 2'd3, 2'd1, 1'b0);
    start_cmp(1'b1, 1'b0, 1'b1, 2'd1, 3'd2);
    drain();

    // write during CMP is rejected and leaves the result unchanged
    start_cmp(1'b1, 1'b0, 1'b1, 2'd1, 3'd2);
    write_el(BANK_B, 2'd0, 2'd3, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("result_hold", 32'({bus.match, bus.mismatch_valid, bus.mismatch_idx}), 32'({1'b0, 1'b1, 2'd1}));

    // write and start in the same cycle: compare sees A[3]=2
    write_el(BANK_B, 2'd1, 2'd2, 1'b0);
    write_el(BANK_B, 2'd3, 2'd0, 1'b0);
    write_start(BANK_A, 2'd3, 2'd2, 1'b0, 1'b1, 2'd3, 3'd1);
    drain();

    // reset in scan cycle 2: no done, banks cleared
    start_cmp(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_midscan", 32'({bus.busy, bus.done, bus.match, bus.mismatch_valid,
                                bus.mismatch_idx, bus.wr_err}), 32'd0);
    rst_n = 1'b1;
    start_cmp(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
    drain();

    // start held high: one done every DEPTH+2 cycles
    write_el(BANK_A, 2'd2, 2'd1, 1'b0);
    for (int n = 0; n < 3; n++)
      exp_q.push_back(pack(cyc + 16'd1 + 16'(DEPTH) + 16'(n * (DEPTH + 2)), 1'b0, 1'b1, 2'd2, 3'd1));
    bus.start = 1'b1;
    repeat (3 * (DEPTH + 2)) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // DEPTH=5 instance: index 5 rejected, index 4 accepted
    bus5.wr_en = 1'b1; bus5.wr_sel = BANK_A; bus5.wr_idx = 3'd5; bus5.wr_data = 2'd3;
    @(negedge clk);
    check("d5_wr_err_idx5", 32'(bus5.wr_err), 32'd1);
    bus5.wr_idx = 3'd4;
    @(negedge clk);
    bus5.wr_en = 1'b0;
    check("d5_wr_err_idx4", 32'(bus5.wr_err), 32'd0);
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    for (int i = 0; i < 20 && !bus5.done; i++) @(negedge clk);
    check("d5_done", 32'(bus5.done), 32'd1);
    check("d5_result", 32'({bus5.match, bus5.mismatch_valid, bus5.mismatch_idx}), 32'({1'b0, 1'b1, 3'd4}));

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
